// File: rtl/bist_pattern_sequencer.sv
// BIST controller for one Nt_Node subcircuit under test.
// An LFSR drives pseudo-random vectors into the SUT. The SUT response bit is
// compacted into a MISR. The final signature is compared against a golden value.
module bist_pattern_sequencer #(
    parameter int          N_IN        = 5,
    parameter int          PAT_COUNT   = 1000,
    parameter int          CAPTURE_LAT = 2,
    parameter logic [15:0] SEED        = 16'h0001
) (
    input  logic            I1470_clk,
    input  logic            I1477_rst,
    input  logic            start,
    input  logic            abort,
    input  logic [15:0]     golden_sig,
    input  logic            sut_out,
    output logic [N_IN-1:0] sut_in,
    output logic            sut_rst,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [15:0]     signature,
    output logic [15:0]     pat_cnt
);

    localparam logic [15:0] POLY       = 16'h6801;
    localparam int          VW         = (CAPTURE_LAT == 0) ? 1 : CAPTURE_LAT;
    localparam logic [15:0] PAT_LAST   = 16'(PAT_COUNT - 1);
    localparam logic [15:0] PAT_MAX    = 16'(PAT_COUNT);
    localparam logic [2:0]  FLUSH_LAST = 3'((CAPTURE_LAT == 0) ? 0 : CAPTURE_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET_SUT,
        S_APPLY,
        S_FLUSH,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [15:0]     lfsr;
    logic [15:0]     misr;
    logic [15:0]     cnt;
    logic [2:0]      phase;
    logic            pass_q;
    logic [N_IN-1:0] last_pat;
    logic [VW-1:0]   vld_p;
    logic [VW:0]     vld_chain;
    logic            vld_in;
    logic            vld_out;

    // Galois LFSR step (x^16 feedback taps 16'h6801)
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], 1'b0} ^ (v[15] ? POLY : 16'h0000);
    endfunction

    // MISR step: same polynomial, response bit folded into bit 0
    function automatic logic [15:0] misr_step(input logic [15:0] v, input logic b);
        return {v[14:0], 1'b0} ^ (v[15] ? POLY : 16'h0000) ^ {15'b0, b};
    endfunction

    // Pattern counter stops at the run length instead of wrapping
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == PAT_MAX) ? v : v + 16'd1;
    endfunction

    // Valid pipe: tap CAPTURE_LAT selects the live input when latency is zero
    assign vld_chain = {vld_p, vld_in};
    assign vld_out   = vld_chain[CAPTURE_LAT];

    assign signature = misr;
    assign pat_cnt   = cnt;
    assign pass      = pass_q;

    // State register
    always_ff @(posedge I1470_clk) begin
        if (I1477_rst) state <= S_IDLE;
        else           state <= state_next;
    end

    // Next-state and Moore outputs; abort overrides every transition
    always_comb begin
        state_next = state;
        sut_rst    = 1'b1;
        busy       = 1'b0;
        done       = 1'b0;
        sut_in     = '0;
        vld_in     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_RESET_SUT;
            end
            S_RESET_SUT: begin
                busy = 1'b1;
                if (phase == 3'd1) state_next = S_APPLY;
            end
            S_APPLY: begin
                busy    = 1'b1;
                sut_rst = 1'b0;
                sut_in  = lfsr[N_IN-1:0];
                vld_in  = 1'b1;
                if (cnt == PAT_LAST)
                    state_next = (CAPTURE_LAT == 0) ? S_COMPARE : S_FLUSH;
            end
            S_FLUSH: begin
                busy    = 1'b1;
                sut_rst = 1'b0;
                sut_in  = last_pat;
                if (phase == FLUSH_LAST) state_next = S_COMPARE;
            end
            S_COMPARE: begin
                busy       = 1'b1;
                sut_rst    = 1'b0;
                sut_in     = last_pat;
                state_next = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) state_next = S_RESET_SUT;
            end
            default: state_next = S_IDLE;
        endcase
        if (abort) state_next = S_IDLE;
    end

    // Sequencer datapath: LFSR, MISR, pattern count, valid pipe, verdict
    always_ff @(posedge I1470_clk) begin
        if (I1477_rst) begin
            lfsr   <= SEED;
            misr   <= 16'h0000;
            cnt    <= 16'h0000;
            vld_p  <= '0;
            phase  <= 3'd0;
            pass_q <= 1'b0;
        end else if (abort) begin
            // misr and cnt keep their values so an aborted run can be inspected
            vld_p  <= '0;
            phase  <= 3'd0;
            pass_q <= 1'b0;
        end else begin
            phase <= (state_next != state) ? 3'd0 : phase + 3'd1;
            vld_p <= vld_chain[VW-1:0];
            if (state_next == S_RESET_SUT) pass_q <= 1'b0;
            case (state)
                S_RESET_SUT: begin
                    lfsr  <= SEED;
                    misr  <= 16'h0000;
                    cnt   <= 16'h0000;
                    vld_p <= '0;
                end
                S_APPLY: begin
                    lfsr <= lfsr_step(lfsr);
                    cnt  <= sat_inc(cnt);
                    if (vld_out) misr <= misr_step(misr, sut_out);
                end
                S_FLUSH: begin
                    if (vld_out) misr <= misr_step(misr, sut_out);
                end
                S_COMPARE: begin
                    pass_q <= (misr == golden_sig);
                end
                default: ;
            endcase
        end
    end

    // Last applied pattern, held on the SUT inputs while the pipe drains
    always_ff @(posedge I1470_clk) begin
        if (state == S_APPLY) last_pat <= lfsr[N_IN-1:0];
    end

endmodule
